// File: rtl/display_pkg.sv
// Shared display constants: default 1440x900@60 raster, renderer region origins, colour types.
package display_pkg;

   localparam int unsigned DEF_H_ACTIVE = 1440;
   localparam int unsigned DEF_H_FP     = 80;
   localparam int unsigned DEF_H_SYNC   = 152;
   localparam int unsigned DEF_H_BP     = 232;
   localparam int unsigned DEF_V_ACTIVE = 900;
   localparam int unsigned DEF_V_FP     = 1;
   localparam int unsigned DEF_V_SYNC   = 3;
   localparam int unsigned DEF_V_BP     = 28;
   localparam int unsigned DEF_FRAME_WRAP = 60;

   localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   // Top-left corners of the regions drawn by the renderers.
   localparam int unsigned OVERLAY_X0 = 64;
   localparam int unsigned OVERLAY_Y0 = 48;
   localparam int unsigned STATUS_X0  = 64;
   localparam int unsigned STATUS_Y0  = 820;

   localparam int unsigned COLOR_W = 4;
   typedef logic [3*COLOR_W-1:0] rgb_t;

   function automatic bit fits_coord(input int unsigned v);
      return v <= 2047;
   endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay.sv
// N-stage, W-bit shift register with a configurable reset value.
module sync_delay #(
   parameter int unsigned N = 3,
   parameter int unsigned W = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [W-1:0] stage_q [N];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) stage_q[i] <= RST_VAL;
      end else begin
         stage_q[0] <= din;
         for (int i = 1; i < N; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign dout = stage_q[N-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters, frame counter and pin-side alignment of sync, blanking and colour.
module vga_timing_gen
   import display_pkg::*;
#(
   parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
   parameter int unsigned H_FP       = DEF_H_FP,
   parameter int unsigned H_SYNC     = DEF_H_SYNC,
   parameter int unsigned H_BP       = DEF_H_BP,
   parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
   parameter int unsigned V_FP       = DEF_V_FP,
   parameter int unsigned V_SYNC     = DEF_V_SYNC,
   parameter int unsigned V_BP       = DEF_V_BP,
   parameter bit          H_POL      = 1'b0,
   parameter bit          V_POL      = 1'b1,
   parameter int unsigned FRAME_WRAP = DEF_FRAME_WRAP,
   parameter int unsigned PIPE_DLY   = 3
) (
   input  logic               clk,
   input  logic               rst,
   output logic [10:0]        pos_x,
   output logic [10:0]        pos_y,
   output logic [5:0]         count,
   output logic               frame_start,
   input  logic [COLOR_W-1:0] pix_r,
   input  logic [COLOR_W-1:0] pix_g,
   input  logic [COLOR_W-1:0] pix_b,
   output logic               hsync,
   output logic               vsync,
   output logic               video_on,
   output logic [COLOR_W-1:0] vga_r,
   output logic [COLOR_W-1:0] vga_g,
   output logic [COLOR_W-1:0] vga_b
);

   localparam int unsigned HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (PIPE_DLY < 1 || PIPE_DLY > 8) begin : g_bad_pipe_dly
      $error("PIPE_DLY must be in 1..8");
   end
   if (FRAME_WRAP < 1 || FRAME_WRAP > 64) begin : g_bad_frame_wrap
      $error("FRAME_WRAP must be in 1..64");
   end
   if (!fits_coord(HT) || !fits_coord(VT)) begin : g_bad_raster
      $error("raster totals must not exceed 2047");
   end

   localparam logic [10:0] H_LAST   = 11'(HT - 1);
   localparam logic [10:0] V_LAST   = 11'(VT - 1);
   localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
   localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
   localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [5:0]  CNT_LAST = 6'(FRAME_WRAP - 1);

   logic [10:0] x_q, x_d, y_q, y_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        line_end, frame_end;

   always_comb begin
      line_end  = (x_q == H_LAST);
      frame_end = line_end && (y_q == V_LAST);
      x_d       = line_end ? 11'd0 : x_q + 11'd1;
      y_d       = y_q;
      cnt_d     = cnt_q;
      if (line_end) y_d = (y_q == V_LAST) ? 11'd0 : y_q + 11'd1;
      if (frame_end) cnt_d = (cnt_q == CNT_LAST) ? 6'd0 : cnt_q + 6'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q   <= '0;
         y_q   <= '0;
         cnt_q <= '0;
      end else begin
         x_q   <= x_d;
         y_q   <= y_d;
         cnt_q <= cnt_d;
      end
   end

   assign pos_x       = x_q;
   assign pos_y       = y_q;
   assign count       = cnt_q;
   assign frame_start = (x_q == 11'd0) && (y_q == 11'd0);

   logic hs_raw, vs_raw, von_raw;

   always_comb begin
      hs_raw  = ((x_q >= HS_START) && (x_q < HS_END)) ? H_POL : !H_POL;
      vs_raw  = ((y_q >= VS_START) && (y_q < VS_END)) ? V_POL : !V_POL;
      von_raw = (x_q < H_VIS) && (y_q < V_VIS);
   end

   logic [2:0] dly;

   sync_delay #(
      .N       (PIPE_DLY),
      .W       (3),
      .RST_VAL ({!H_POL, !V_POL, 1'b0})
   ) u_sync_delay (
      .clk  (clk),
      .rst  (rst),
      .din  ({hs_raw, vs_raw, von_raw}),
      .dout (dly)
   );

   // Final register stage shared by sync and colour so every pin sees PIPE_DLY+1 latency.
   logic hs_q, vs_q, von_q;
   rgb_t rgb_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hs_q  <= !H_POL;
         vs_q  <= !V_POL;
         von_q <= 1'b0;
         rgb_q <= '0;
      end else begin
         hs_q  <= dly[2];
         vs_q  <= dly[1];
         von_q <= dly[0];
         rgb_q <= dly[0] ? {pix_r, pix_g, pix_b} : '0;
      end
   end

   assign hsync    = hs_q;
   assign vsync    = vs_q;
   assign video_on = von_q;
   assign {vga_r, vga_g, vga_b} = rgb_q;

endmodule
